// File: rtl/nqueens_run_controller_pkg.sv
// Shared definitions for the N-Queens sweep controller: board-size limits,
// accelerator sum width and the sweep FSM state encoding.
package nqueens_run_controller_pkg;

  localparam int NQ_N_MIN  = 4;
  localparam int NQ_N_MAX  = 16;
  localparam int NQ_SUM_W  = 64;
  localparam int DISP_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } run_state_t;

endpackage

// File: rtl/nqueens_display_pager.sv
// Pages a 64-bit result onto a 32-bit display word, alternating low/high
// halves every DWELL cycles; a restart pulse returns to the low half.
module nqueens_display_pager
  import nqueens_run_controller_pkg::*;
#(
  parameter int DWELL = 2**28,
  parameter int SUM_W = NQ_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [SUM_W-1:0]  result,
  output logic [DISP_W-1:0] disp_word,
  output logic              disp_page
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] dwell;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dwell     <= '0;
      disp_page <= 1'b0;
    end else if (restart) begin
      dwell     <= '0;
      disp_page <= 1'b0;
    end else if (dwell == DW_LAST) begin
      dwell     <= '0;
      disp_page <= ~disp_page;
    end else begin
      dwell     <= dwell + DW_W'(1);
    end
  end

  assign disp_word = disp_page ? result[2*DISP_W-1:DISP_W] : result[DISP_W-1:0];

endmodule

// File: rtl/nqueens_run_controller.sv
// Sweeps the N-Queens accelerator over n_first..n_last: resets it per board
// size, waits for done (with optional timeout), captures and pages the sum.
module nqueens_run_controller
  import nqueens_run_controller_pkg::*;
#(
  parameter int              N_W        = 5,
  parameter int              N_MIN      = NQ_N_MIN,
  parameter int              N_MAX      = NQ_N_MAX,
  parameter int              SUM_W      = NQ_SUM_W,
  parameter int              RST_CYCLES = 2,
  parameter int              DWELL      = 2**28,
  parameter longint unsigned TIMEOUT    = 64'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_W-1:0]    n_first,
  input  logic [N_W-1:0]    n_last,
  output logic              acc_reset,
  output logic [N_W-1:0]    acc_n,
  input  logic              acc_done,
  input  logic [SUM_W-1:0]  acc_sum,
  output logic              busy,
  output logic              result_vld,
  output logic [N_W-1:0]    result_n,
  output logic [SUM_W-1:0]  result,
  output logic [DISP_W-1:0] disp_word,
  output logic              disp_page,
  output logic              timeout
);

  localparam int              LC_W    = $clog2(RST_CYCLES + 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(RST_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0]     TO_LAST = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

  // acc_n+1 stays in range only if the largest board size fits in N_W bits
  if (N_MAX >= (1 << N_W)) begin : g_bad_nmax
    $error("N_MAX does not fit in N_W bits");
  end
  if (SUM_W != 2 * DISP_W) begin : g_bad_sumw
    $error("SUM_W must be twice the display width");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("RST_CYCLES must be at least 1");
  end

  run_state_t      state;
  logic [N_W-1:0]  lo_c, hi_c, hi;
  logic [LC_W-1:0] launch_cnt;
  logic [31:0]     wait_cnt;
  logic            capture_fire;

  always_comb begin
    lo_c = (n_first < N_W'(N_MIN)) ? N_W'(N_MIN) : n_first;
    hi_c = (n_last  > N_W'(N_MAX)) ? N_W'(N_MAX) : n_last;
  end

  assign capture_fire = (state == S_CAPTURE) && !abort;

  // Launch spans the start/capture edge plus RST_CYCLES further cycles of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      acc_reset  <= 1'b1;
      acc_n      <= N_W'(N_MIN);
      hi         <= N_W'(N_MAX);
      launch_cnt <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      result_vld <= 1'b0;
      result_n   <= '0;
      result     <= '0;
      timeout    <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        acc_reset <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            acc_reset <= 1'b1;
            busy      <= 1'b0;
            if (start) begin
              timeout <= 1'b0;
              if (lo_c > hi_c) begin
                state <= S_DONE;
              end else begin
                acc_n      <= lo_c;
                hi         <= hi_c;
                launch_cnt <= '0;
                busy       <= 1'b1;
                state      <= S_LAUNCH;
              end
            end
          end
          S_LAUNCH: begin
            if (launch_cnt == LC_LAST) begin
              acc_reset <= 1'b0;
              wait_cnt  <= '0;
              state     <= S_RUN;
            end else begin
              launch_cnt <= launch_cnt + LC_W'(1);
            end
          end
          S_RUN: begin
            if (acc_done) begin
              state <= S_CAPTURE;
            end else if (TO_EN && (wait_cnt == TO_LAST)) begin
              timeout   <= 1'b1;
              acc_reset <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              wait_cnt <= wait_cnt + 32'd1;
            end
          end
          S_CAPTURE: begin
            result     <= acc_sum;
            result_n   <= acc_n;
            result_vld <= 1'b1;
            acc_reset  <= 1'b1;
            launch_cnt <= '0;
            if (acc_n == hi) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              acc_n <= acc_n + N_W'(1);
              state <= S_LAUNCH;
            end
          end
          S_DONE: begin
            acc_reset <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
          default: begin
            acc_reset <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

  nqueens_display_pager #(
    .DWELL (DWELL),
    .SUM_W (SUM_W)
  ) u_pager (
    .clk       (clk),
    .rst       (rst),
    .restart   (capture_fire),
    .result    (result),
    .disp_word (disp_word),
    .disp_page (disp_page)
  );

endmodule

// File: tb/tb_nqueens_run_controller.sv
// Bench for nqueens_run_controller: an accelerator stand-in, a closed-form
// timeline model checked every cycle, and literal expectations per scenario.
module tb_nqueens_run_controller;

  localparam int R   = 2;
  localparam int DW  = 4;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  n_first = '0;
  logic [4:0]  n_last = '0;
  logic        acc_reset;
  logic [4:0]  acc_n;
  logic        acc_done;
  logic [63:0] acc_sum;
  logic        busy;
  logic        result_vld;
  logic [4:0]  result_n;
  logic [63:0] result;
  logic [31:0] disp_word;
  logic        disp_page;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nqueens_run_controller #(
    .RST_CYCLES (R),
    .DWELL      (DW),
    .TIMEOUT    (64'd100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_first    (n_first),
    .n_last     (n_last),
    .acc_reset  (acc_reset),
    .acc_n      (acc_n),
    .acc_done   (acc_done),
    .acc_sum    (acc_sum),
    .busy       (busy),
    .result_vld (result_vld),
    .result_n   (result_n),
    .result     (result),
    .disp_word  (disp_word),
    .disp_page  (disp_page),
    .timeout    (timeout)
  );

  function automatic logic [63:0] nq_count(input int n);
    case (n)
      1: return 64'd1;          4: return 64'd2;          5: return 64'd10;
      6: return 64'd4;          7: return 64'd40;         8: return 64'd92;
      9: return 64'd352;        10: return 64'd724;       11: return 64'd2680;
      12: return 64'd14200;     13: return 64'd73712;     14: return 64'd365596;
      15: return 64'd2279184;   16: return 64'd14772512;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accelerator stand-in: done after lat released cycles, never if acc_never.
  int          lat = 3;
  bit          acc_never = 1'b0;
  bit          ovr_en = 1'b0;
  logic [63:0] ovr = '0;
  int          acc_cyc = 0;

  always @(posedge clk) acc_cyc <= acc_reset ? 0 : ((acc_cyc < 100000) ? acc_cyc + 1 : acc_cyc);
  assign acc_done = !acc_reset && !acc_never && (acc_cyc >= lat);
  assign acc_sum  = ovr_en ? ovr : nq_count(int'(acc_n));

  // Timeline model: each launch releases reset 1+R edges after start/capture,
  // done is seen lat+1 edges after release, capture one edge later.
  int          cyc = 0;
  bit          model_ok = 1'b0;
  bit          act = 1'b0;
  bit          tmode = 1'b0;
  int          k0, lo_m, hi_m, d_m, idle_at, restart_at;
  bit          e_rst, e_busy, e_vld, e_tmo;
  int          e_accn, e_resn;
  logic [63:0] e_res;

  always @(posedge clk) begin
    int lo, hi, f0, per, p, i, q;
    cyc++;
    e_vld = 1'b0;
    if (!rst) begin
      act = 1'b0; e_rst = 1'b1; e_busy = 1'b0; e_accn = 4; e_resn = 0;
      e_res = '0; e_tmo = 1'b0; restart_at = cyc; idle_at = cyc + 1; model_ok = 1'b1;
    end else if (!model_ok) begin
      act = 1'b0;
    end else if (abort) begin
      act = 1'b0; e_rst = 1'b1; e_busy = 1'b0; idle_at = cyc + 1;
    end else if (act) begin
      f0 = k0 + 1 + R;
      if (cyc < f0) begin
        e_rst = 1'b1;
      end else if (tmode) begin
        if (cyc - f0 == TMO) begin
          e_tmo = 1'b1; e_busy = 1'b0; e_rst = 1'b1; act = 1'b0; idle_at = cyc + 2;
        end else begin
          e_rst = 1'b0;
        end
      end else begin
        per = d_m + R + 2;
        p = cyc - f0; i = p / per; q = p % per;
        e_rst = (q > d_m);
        if (q == d_m + 1) begin
          e_vld = 1'b1; e_resn = lo_m + i;
          e_res = ovr_en ? ovr : nq_count(e_resn);
          restart_at = cyc;
          if (lo_m + i == hi_m) begin
            e_busy = 1'b0; act = 1'b0; idle_at = cyc + 2;
          end else begin
            e_accn = lo_m + i + 1;
          end
        end
      end
    end else if (start && cyc >= idle_at) begin
      lo = (int'(n_first) < 4) ? 4 : int'(n_first);
      hi = (int'(n_last) > 16) ? 16 : int'(n_last);
      e_tmo = 1'b0;
      if (lo > hi) begin
        idle_at = cyc + 2;
      end else begin
        act = 1'b1; k0 = cyc; lo_m = lo; hi_m = hi; tmode = acc_never;
        d_m = lat + 1; e_accn = lo; e_busy = 1'b1; e_rst = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e_page;
    if (model_ok) begin
      e_page = 64'(((cyc - restart_at) / DW) % 2);
      chk("acc_reset",  64'(acc_reset),  64'(e_rst));
      chk("busy",       64'(busy),       64'(e_busy));
      chk("result_vld", 64'(result_vld), 64'(e_vld));
      chk("acc_n",      64'(acc_n),      64'(e_accn));
      chk("result_n",   64'(result_n),   64'(e_resn));
      chk("result",     result,          e_res);
      chk("timeout",    64'(timeout),    64'(e_tmo));
      chk("disp_page",  64'(disp_page),  e_page);
      chk("disp_word",  64'(disp_word),  e_page[0] ? 64'(e_res[63:32]) : 64'(e_res[31:0]));
    end
  end

  int          cap_n[$];
  logic [63:0] cap_s[$];

  always @(negedge clk) begin
    if (rst === 1'b1 && result_vld === 1'b1) begin
      cap_n.push_back(int'(result_n));
      cap_s.push_back(result);
    end
  end

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    n_first = f; n_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n, t1, t2;
    logic [63:0] sums2 [5];
    logic [31:0] exp_disp [12];
    sums2    = '{64'd2, 64'd10, 64'd4, 64'd40, 64'd92};
    exp_disp = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1,
                 32'd2, 32'd2, 32'd2, 32'd2};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_acc_reset", 64'(acc_reset), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_result",    result,         64'd0);
    chk("rst_disp_page", 64'(disp_page), 64'd0);
    chk("rst_timeout",   64'(timeout),   64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // sweep 4..8
    cap_n.delete(); cap_s.delete();
    pulse_start(5'd4, 5'd8);
    n = 0;
    while (acc_reset === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("launch_latency", 64'(n), 64'(1 + R));
    wait_idle("sweep48_bound");
    chk("sweep48_count", 64'(cap_n.size()), 64'd5);
    for (int i = 0; i < 5 && i < cap_n.size(); i++) begin
      chk("sweep48_n",   64'(cap_n[i]), 64'(4 + i));
      chk("sweep48_sum", cap_s[i],      sums2[i]);
    end

    // clamped sweep 2..20 -> 4..16
    cap_n.delete(); cap_s.delete();
    pulse_start(5'd2, 5'd20);
    wait_idle("sweep_clamp_bound");
    chk("clamp_count", 64'(cap_n.size()), 64'd13);
    if (cap_n.size() == 13) begin
      chk("clamp_first_n", 64'(cap_n[0]),  64'd4);
      chk("clamp_last_n",  64'(cap_n[12]), 64'd16);
      chk("clamp_last_sum", cap_s[12],     64'd14772512);
    end

    // empty range
    cap_n.delete(); cap_s.delete();
    pulse_start(5'd9, 5'd5);
    repeat (20) @(negedge clk);
    chk("empty_count", 64'(cap_n.size()), 64'd0);
    chk("empty_busy",  64'(busy),         64'd0);

    // timeout
    acc_never = 1'b1;
    pulse_start(5'd4, 5'd5);
    n = 0;
    while (acc_reset === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    chk("timeout_cycles", 64'(t2 - t1), 64'd100);
    chk("timeout_busy",   64'(busy),    64'd0);
    repeat (3) @(negedge clk);
    acc_never = 1'b0;

    // abort together with start, mid-RUN at N=6
    lat = 10;
    pulse_start(5'd4, 5'd8);
    n = 0;
    while (!(acc_n === 5'd6 && acc_reset === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_n6", 64'(n < 300), 64'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_acc_reset", 64'(acc_reset), 64'd1);
    chk("abort_busy",      64'(busy),      64'd0);
    chk("abort_result_n",  64'(result_n),  64'd5);
    chk("abort_result",    result,         64'd10);
    repeat (5) @(negedge clk);

    // display paging, then reset mid-sweep
    lat = 30; ovr_en = 1'b1; ovr = 64'h0000_0001_0000_0002;
    pulse_start(5'd4, 5'd8);
    n = 0;
    while (result_vld !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("disp_capture_seen", 64'(n < 300), 64'd1);
    for (int i = 0; i < 12; i++) begin
      chk("disp_seq", 64'(disp_word), 64'(exp_disp[i]));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_acc_reset", 64'(acc_reset), 64'd1);
    chk("mid_rst_busy",      64'(busy),      64'd0);
    chk("mid_rst_result",    result,         64'd0);
    chk("mid_rst_result_n",  64'(result_n),  64'd0);
    chk("mid_rst_acc_n",     64'(acc_n),     64'd4);
    chk("mid_rst_disp_page", 64'(disp_page), 64'd0);
    chk("mid_rst_timeout",   64'(timeout),   64'd0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
